// File: rtl/axi4_csr_master.sv
// Single-clock AXI4-Lite initiator: one CSR word read or write at a time,
// answered by a one-cycle response pulse, with an optional response timeout.
module axi4_csr_master #(
  parameter int g_addr_bits      = 16,
  parameter int g_timeout_cycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [g_addr_bits-1:0] req_adr_i,
  input  logic [31:0]            req_dat_i,
  input  logic [3:0]             req_sel_i,
  output logic                   rsp_valid_o,
  output logic                   rsp_err_o,
  output logic [31:0]            rsp_dat_o,
  output logic [31:0]            m_axil_AWADDR,
  output logic                   m_axil_AWVALID,
  input  logic                   m_axil_AWREADY,
  output logic [31:0]            m_axil_WDATA,
  output logic [3:0]             m_axil_WSTRB,
  output logic                   m_axil_WVALID,
  input  logic                   m_axil_WREADY,
  input  logic [1:0]             m_axil_BRESP,
  input  logic                   m_axil_BVALID,
  output logic                   m_axil_BREADY,
  output logic [31:0]            m_axil_ARADDR,
  output logic                   m_axil_ARVALID,
  input  logic                   m_axil_ARREADY,
  input  logic [31:0]            m_axil_RDATA,
  input  logic [1:0]             m_axil_RRESP,
  input  logic                   m_axil_RVALID,
  output logic                   m_axil_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  localparam int c_cnt_bits = (g_timeout_cycles > 2) ? $clog2(g_timeout_cycles) : 1;
  localparam logic [c_cnt_bits-1:0] c_cnt_last =
    c_cnt_bits'((g_timeout_cycles > 0) ? g_timeout_cycles - 1 : 0);
  localparam bit c_tmo_en = (g_timeout_cycles > 0);

  state_t                r_state;
  logic                  r_is_wr;
  logic [c_cnt_bits-1:0] r_cnt;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic                  r_rsp_valid, r_rsp_err;
  logic [31:0]           r_rsp_dat;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic w_aw_fin, w_w_fin, w_ar_fin;
  logic w_busy, w_tmo;
  logic w_unused;

  assign w_aw_hs  = r_awvalid & m_axil_AWREADY;
  assign w_w_hs   = r_wvalid & m_axil_WREADY;
  assign w_ar_hs  = r_arvalid & m_axil_ARREADY;
  assign w_b_hs   = r_bready & m_axil_BVALID;
  assign w_r_hs   = r_rready & m_axil_RVALID;
  // A request channel is finished once its VALID is low or handshaking now.
  assign w_aw_fin = ~r_awvalid | w_aw_hs;
  assign w_w_fin  = ~r_wvalid | w_w_hs;
  assign w_ar_fin = ~r_arvalid | w_ar_hs;
  assign w_busy   = (r_state != S_IDLE) && (r_state != S_DRAIN);
  assign w_tmo    = c_tmo_en && w_busy && (r_cnt == c_cnt_last);
  assign w_unused = ^{m_axil_BRESP[0], m_axil_RRESP[0]};

  // Transaction sequencer with registered AXI and response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_is_wr     <= 1'b0;
      r_cnt       <= '0;
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_wstrb     <= 4'h0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= 32'h0000_0000;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_aw_hs) r_awvalid <= 1'b0;
      if (w_w_hs)  r_wvalid  <= 1'b0;
      if (w_ar_hs) r_arvalid <= 1'b0;
      if (w_busy)  r_cnt     <= r_cnt + c_cnt_bits'(1);
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_addr  <= 32'({req_adr_i, 2'b00});
            r_wdata <= req_dat_i;
            r_wstrb <= req_sel_i;
            r_cnt   <= '0;
            r_is_wr <= req_we_i;
            if (req_we_i) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
          if (w_tmo) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= S_DRAIN;
          end
        end
        S_WR_RESP: begin
          if (w_b_hs) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= m_axil_BRESP[1];
            r_state     <= S_IDLE;
          end else if (w_tmo) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= S_DRAIN;
          end
        end
        S_RD_REQ: begin
          if (w_ar_hs) begin
            r_rready <= 1'b1;
            r_state  <= S_RD_RESP;
          end
          if (w_tmo) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= S_DRAIN;
          end
        end
        S_RD_RESP: begin
          if (w_r_hs) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= m_axil_RRESP[1];
            r_rsp_dat   <= m_axil_RDATA;
            r_state     <= S_IDLE;
          end else if (w_tmo) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= S_DRAIN;
          end
        end
        // Finish the abandoned transaction silently so the slave stays in step.
        S_DRAIN: begin
          if (r_is_wr) begin
            if (w_b_hs) begin
              r_bready <= 1'b0;
              r_state  <= S_IDLE;
            end else if (w_aw_fin && w_w_fin) begin
              r_bready <= 1'b1;
            end
          end else begin
            if (w_r_hs) begin
              r_rready <= 1'b0;
              r_state  <= S_IDLE;
            end else if (w_ar_fin) begin
              r_rready <= 1'b1;
            end
          end
        end
        default: begin
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o    = (r_state == S_IDLE) & ~rst_i;
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_err_o      = r_rsp_err;
  assign rsp_dat_o      = r_rsp_dat;
  assign m_axil_AWADDR  = r_addr;
  assign m_axil_AWVALID = r_awvalid;
  assign m_axil_WDATA   = r_wdata;
  assign m_axil_WSTRB   = r_wstrb;
  assign m_axil_WVALID  = r_wvalid;
  assign m_axil_BREADY  = r_bready;
  assign m_axil_ARADDR  = r_addr;
  assign m_axil_ARVALID = r_arvalid;
  assign m_axil_RREADY  = r_rready;

endmodule

// File: tb/tb_axi4_csr_master.sv
// Scoreboard bench for axi4_csr_master: directed CSR requests against a
// delay-configurable AXI4-Lite slave model; a monitor checks every response pulse.
module tb_axi4_csr_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [15:0] req_adr_i;
  logic [31:0] req_dat_i;
  logic [3:0]  req_sel_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic [31:0] m_axil_AWADDR, m_axil_WDATA, m_axil_ARADDR, m_axil_RDATA;
  logic [3:0]  m_axil_WSTRB;
  logic        m_axil_AWVALID, m_axil_AWREADY, m_axil_WVALID, m_axil_WREADY;
  logic        m_axil_BVALID, m_axil_BREADY, m_axil_ARVALID, m_axil_ARREADY;
  logic        m_axil_RVALID, m_axil_RREADY;
  logic [1:0]  m_axil_BRESP, m_axil_RRESP;

  axi4_csr_master #(.g_addr_bits(16), .g_timeout_cycles(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_dat_o(rsp_dat_o),
    .m_axil_AWADDR(m_axil_AWADDR), .m_axil_AWVALID(m_axil_AWVALID), .m_axil_AWREADY(m_axil_AWREADY),
    .m_axil_WDATA(m_axil_WDATA), .m_axil_WSTRB(m_axil_WSTRB), .m_axil_WVALID(m_axil_WVALID),
    .m_axil_WREADY(m_axil_WREADY), .m_axil_BRESP(m_axil_BRESP), .m_axil_BVALID(m_axil_BVALID),
    .m_axil_BREADY(m_axil_BREADY), .m_axil_ARADDR(m_axil_ARADDR), .m_axil_ARVALID(m_axil_ARVALID),
    .m_axil_ARREADY(m_axil_ARREADY), .m_axil_RDATA(m_axil_RDATA), .m_axil_RRESP(m_axil_RRESP),
    .m_axil_RVALID(m_axil_RVALID), .m_axil_RREADY(m_axil_RREADY)
  );

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [31:0] cfg_rdata = 32'h0;
  logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  initial forever #5 clk_i = ~clk_i;
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // AXI4-Lite slave model, updated on the falling edge
  initial begin
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    bit aw_got, w_got, ar_got, b_fire, r_fire;
    m_axil_AWREADY = 1'b0; m_axil_WREADY = 1'b0; m_axil_ARREADY = 1'b0;
    m_axil_BVALID = 1'b0; m_axil_BRESP = 2'b00;
    m_axil_RVALID = 1'b0; m_axil_RRESP = 2'b00; m_axil_RDATA = 32'h0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        m_axil_AWREADY = 1'b0; m_axil_WREADY = 1'b0; m_axil_ARREADY = 1'b0;
        m_axil_BVALID = 1'b0; m_axil_RVALID = 1'b0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
      end else begin
        if (b_fire) begin m_axil_BVALID = 1'b0; b_fire = 0; aw_got = 0; w_got = 0; b_wait = 0; end
        if (r_fire) begin m_axil_RVALID = 1'b0; r_fire = 0; ar_got = 0; r_wait = 0; end
        if (aw_got && w_got && !m_axil_BVALID) begin
          if (b_wait >= b_delay) begin m_axil_BVALID = 1'b1; m_axil_BRESP = cfg_bresp; end
          else b_wait++;
        end
        if (ar_got && !m_axil_RVALID) begin
          if (r_wait >= r_delay) begin
            m_axil_RVALID = 1'b1; m_axil_RDATA = cfg_rdata; m_axil_RRESP = cfg_rresp;
          end else r_wait++;
        end
        if (m_axil_AWVALID && !aw_got) begin
          m_axil_AWREADY = (aw_wait >= aw_delay); aw_wait++;
          if (m_axil_AWREADY) begin aw_got = 1; cap_awaddr = m_axil_AWADDR; end
        end else begin m_axil_AWREADY = 1'b0; aw_wait = 0; end
        if (m_axil_WVALID && !w_got) begin
          m_axil_WREADY = (w_wait >= w_delay); w_wait++;
          if (m_axil_WREADY) begin w_got = 1; cap_wdata = m_axil_WDATA; cap_wstrb = m_axil_WSTRB; end
        end else begin m_axil_WREADY = 1'b0; w_wait = 0; end
        if (m_axil_ARVALID && !ar_got) begin
          m_axil_ARREADY = (ar_wait >= ar_delay); ar_wait++;
          if (m_axil_ARREADY) begin ar_got = 1; cap_araddr = m_axil_ARADDR; end
        end else begin m_axil_ARREADY = 1'b0; ar_wait = 0; end
        if (m_axil_BVALID && m_axil_BREADY) b_fire = 1;
        if (m_axil_RVALID && m_axil_RREADY) r_fire = 1;
      end
    end
  end

  // Response monitor: pops the scoreboard on every pulse, plus channel ordering checks
  initial forever begin
    exp_t e;
    @(negedge clk_i);
    if (!rst_i) begin
      if (rsp_valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid_o), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
          chk("rsp_dat", rsp_dat_o, e.dat);
          if (e.exp_cyc >= 0) chk("rsp_cycle", 32'(cyc), 32'(e.exp_cyc));
        end
      end
      if (m_axil_BREADY) chk("bready_before_req_done", 32'(m_axil_AWVALID | m_axil_WVALID), 32'h0);
      if (m_axil_ARVALID) chk("ar_with_write", 32'(m_axil_AWVALID | m_axil_WVALID | m_axil_BREADY), 32'h0);
      if (m_axil_RREADY) chk("rready_before_ar_done", 32'(m_axil_ARVALID), 32'h0);
    end
  end

  task automatic issue(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic e_err, input logic [31:0] e_dat,
                       input int lat, output int n);
    exp_t e;
    bit   ok;
    @(negedge clk_i);
    req_we_i = we; req_adr_i = adr; req_dat_i = dat; req_sel_i = sel; req_valid_i = 1'b1;
    ok = 0;
    n  = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready_o) begin ok = 1; break; end
      @(negedge clk_i);
    end
    if (ok) begin
      n = cyc;
      e.err = e_err; e.dat = e_dat; e.exp_cyc = (lat < 0) ? -1 : n + lat;
      sb.push_back(e);
      @(negedge clk_i);
    end else begin
      chk("req_accept", 32'h0, 32'h1);
    end
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (req_ready_o && sb.size() == 0) begin ok = 1; break; end
      @(negedge clk_i);
    end
    if (!ok) chk("idle_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_adr_i = 16'h0; req_dat_i = 32'h0; req_sel_i = 4'h0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("reset_outputs", {23'h0, m_axil_AWVALID, m_axil_WVALID, m_axil_BREADY, m_axil_ARVALID,
                          m_axil_RREADY, rsp_valid_o, rsp_err_o, req_ready_o}, 32'h0);
    chk("reset_rsp_dat", rsp_dat_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 chk("ready_after_reset", 32'(req_ready_o), 32'h1);

    // 1: write, slave always ready
    issue(1'b1, 16'h0010, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 3, n);
    wait_idle(40);
    chk("t1_awaddr", cap_awaddr, 32'h0000_0040);
    chk("t1_wdata", cap_wdata, 32'hCAFE_F00D);
    chk("t1_wstrb", 32'(cap_wstrb), 32'hF);

    // 2: read with RVALID delayed 5 cycles
    cfg_rdata = 32'h1234_5678; r_delay = 5;
    issue(1'b0, 16'h0004, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 8, n);
    wait_idle(40);
    chk("t2_araddr", cap_araddr, 32'h0000_0010);
    r_delay = 0;

    // 3: WREADY three cycles ahead of AWREADY
    aw_delay = 3;
    issue(1'b1, 16'h0123, 32'h0BAD_BEEF, 4'h3, 1'b0, 32'h1234_5678, 6, n);
    chk("t3_both_valid", {30'h0, m_axil_AWVALID, m_axil_WVALID}, 32'h3);
    wait_cyc(n + 2);
    chk("t3_w_dropped", {29'h0, m_axil_AWVALID, m_axil_WVALID, m_axil_BREADY}, 32'h4);
    wait_cyc(n + 4);
    chk("t3_aw_held", {30'h0, m_axil_AWVALID, m_axil_BREADY}, 32'h2);
    wait_cyc(n + 5);
    chk("t3_bready", {30'h0, m_axil_AWVALID, m_axil_BREADY}, 32'h1);
    wait_idle(40);
    chk("t3_awaddr", cap_awaddr, 32'h0000_048C);
    chk("t3_wstrb", 32'(cap_wstrb), 32'h3);
    aw_delay = 0;

    // 4: error responses, top word address
    cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b10;
    issue(1'b0, 16'hFFFF, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 3, n);
    wait_idle(40);
    chk("t4_araddr", cap_araddr, 32'h0003_FFFC);
    cfg_rresp = 2'b00; cfg_bresp = 2'b11;
    issue(1'b1, 16'h0020, 32'h55AA_55AA, 4'h5, 1'b1, 32'hDEAD_BEEF, 3, n);
    wait_idle(40);
    cfg_bresp = 2'b01;
    issue(1'b1, 16'h0021, 32'h0000_0001, 4'h1, 1'b0, 32'hDEAD_BEEF, 3, n);
    wait_idle(40);
    cfg_bresp = 2'b00;

    // 5: ARREADY held off for 40 cycles, timeout is 16
    ar_delay = 40; cfg_rdata = 32'h1111_2222;
    issue(1'b0, 16'h0008, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 17, n);
    wait_cyc(n + 20);
    chk("t5_drain_arvalid", {30'h0, m_axil_ARVALID, req_ready_o}, 32'h2);
    wait_cyc(n + 41);
    chk("t5_drain_late", {30'h0, m_axil_ARVALID, req_ready_o}, 32'h2);
    wait_idle(100);
    chk("t5_idle_cycle", 32'(cyc), 32'(n + 43));
    chk("t5_araddr", cap_araddr, 32'h0000_0020);
    chk("t5_dat_held", rsp_dat_o, 32'hDEAD_BEEF);
    ar_delay = 0;
    repeat (3) @(negedge clk_i);

    // 6: reset while AWVALID is high
    aw_delay = 10; w_delay = 10;
    issue(1'b1, 16'h0001, 32'h0000_0001, 4'h1, 1'b0, 32'h0, -1, n);
    wait_cyc(n + 2);
    chk("t6_awvalid_pre", 32'(m_axil_AWVALID), 32'h1);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_reset_outputs", {24'h0, m_axil_AWVALID, m_axil_WVALID, m_axil_BREADY, m_axil_ARVALID,
                             m_axil_RREADY, rsp_valid_o, req_ready_o, rsp_err_o}, 32'h0);
    chk("t6_reset_dat", rsp_dat_o, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0; aw_delay = 0; w_delay = 0;
    #1 chk("t6_ready_after", 32'(req_ready_o), 32'h1);
    cfg_rdata = 32'hA5A5_5A5A;
    issue(1'b0, 16'h0002, 32'h0, 4'h0, 1'b0, 32'hA5A5_5A5A, 3, n);
    wait_idle(40);
    chk("t6_araddr", cap_araddr, 32'h0000_0008);

    repeat (3) @(negedge clk_i);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
